// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the P4 memory stage and data memory.
// The master holds req, we, addr and wdata stable until it sees a one-cycle ack.
interface mem_stage_if;
    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        ack;

    modport master (
        output req,
        output we,
        output addr,
        output wdata,
        input  rdata,
        input  ack
    );

    modport slave (
        input  req,
        input  we,
        input  addr,
        input  wdata,
        output rdata,
        output ack
    );
endinterface

// File: rtl/mem_stage.sv
// P4 memory-access stage: issues loads/stores on the dmem handshake, stalls execute while an
// access is outstanding and registers the P5 writeback bundle. Sticky misalign/timeout errors.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// ST_IDLE | no access outstanding; non-mem ops pass through in one cycle
// ST_WAIT | request on the bus, waiting for dmem.ack or the timeout count
module mem_stage #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] dest_reg_value_ixmem_p4,
    input  logic [2:0]  dest_reg_index_ixmem_p4,
    input  logic        dest_reg_write_valid_ixmem_p4,
    input  logic [15:0] mem_addr_ixmem_p4,
    input  logic        ldst_valid_ixmem_p4,
    input  logic [1:0]  store_valid_ixmem_p4,
    input  logic [15:0] mem_data_in_ixmem_p4,
    input  logic [15:0] pc_p4,
    output logic        stall_mem_p4,
    mem_stage_if.master dmem,
    output logic [15:0] wb_value_mxwb_p5,
    output logic [2:0]  wb_index_mxwb_p5,
    output logic        wb_valid_mxwb_p5,
    output logic [15:0] pc_p5,
    output logic        err_unaligned,
    output logic        err_timeout
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYC - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] wb_value_q, wb_value_d;
    logic [2:0]  wb_index_q, wb_index_d;
    logic        wb_valid_q, wb_valid_d;
    logic [15:0] pc5_q, pc5_d;
    logic        err_unaligned_q, err_unaligned_d;
    logic        err_timeout_q, err_timeout_d;

    logic mem_op;
    logic misaligned;
    logic is_load;
    logic is_stu;
    logic cnt_last;
    logic result_wv;

    assign mem_op     = ldst_valid_ixmem_p4 & ~mem_addr_ixmem_p4[0];
    assign misaligned = ldst_valid_ixmem_p4 & mem_addr_ixmem_p4[0];
    assign is_load    = (store_valid_ixmem_p4 == 2'b00);
    assign is_stu     = (store_valid_ixmem_p4 == 2'b10);
    assign cnt_last   = (cnt_q == CNT_LAST);

    // Plain stores (01 and the illegal 11) never write a register; STU always writes the address.
    assign result_wv  = is_load ? dest_reg_write_valid_ixmem_p4 : is_stu;

    // An ack in the last counted cycle still completes the access, so it masks the timeout.
    assign stall_mem_p4 = ((state_q == ST_IDLE) & mem_op)
                        | ((state_q == ST_WAIT) & ~dmem.ack & ~cnt_last);

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        req_d           = req_q;
        we_d            = we_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        wb_value_d      = wb_value_q;
        wb_index_d      = wb_index_q;
        wb_valid_d      = wb_valid_q;
        pc5_d           = pc5_q;
        err_unaligned_d = err_unaligned_q;
        err_timeout_d   = err_timeout_q;

        case (state_q)
            ST_IDLE: begin
                if (mem_op) begin
                    state_d    = ST_WAIT;
                    cnt_d      = 16'd0;
                    req_d      = 1'b1;
                    we_d       = |store_valid_ixmem_p4;
                    addr_d     = {mem_addr_ixmem_p4[15:1], 1'b0};
                    wdata_d    = mem_data_in_ixmem_p4;
                    wb_value_d = 16'd0;
                    wb_index_d = 3'd0;
                    wb_valid_d = 1'b0;
                    pc5_d      = 16'd0;
                end else begin
                    // Non-mem ops pass through; a misaligned access retires with its write suppressed.
                    wb_value_d = dest_reg_value_ixmem_p4;
                    wb_index_d = dest_reg_index_ixmem_p4;
                    wb_valid_d = dest_reg_write_valid_ixmem_p4 & ~misaligned;
                    pc5_d      = pc_p4;
                    if (misaligned) begin
                        err_unaligned_d = 1'b1;
                    end
                end
            end

            ST_WAIT: begin
                if (dmem.ack) begin
                    state_d    = ST_IDLE;
                    req_d      = 1'b0;
                    we_d       = 1'b0;
                    wb_value_d = is_load ? dmem.rdata : dest_reg_value_ixmem_p4;
                    wb_index_d = dest_reg_index_ixmem_p4;
                    wb_valid_d = result_wv;
                    pc5_d      = pc_p4;
                end else begin
                    wb_value_d = 16'd0;
                    wb_index_d = 3'd0;
                    wb_valid_d = 1'b0;
                    pc5_d      = 16'd0;
                    if (cnt_last) begin
                        state_d       = ST_IDLE;
                        req_d         = 1'b0;
                        we_d          = 1'b0;
                        err_timeout_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
                we_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= ST_IDLE;
            cnt_q           <= 16'd0;
            req_q           <= 1'b0;
            we_q            <= 1'b0;
            addr_q          <= 16'd0;
            wdata_q         <= 16'd0;
            wb_value_q      <= 16'd0;
            wb_index_q      <= 3'd0;
            wb_valid_q      <= 1'b0;
            pc5_q           <= 16'd0;
            err_unaligned_q <= 1'b0;
            err_timeout_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            req_q           <= req_d;
            we_q            <= we_d;
            addr_q          <= addr_d;
            wdata_q         <= wdata_d;
            wb_value_q      <= wb_value_d;
            wb_index_q      <= wb_index_d;
            wb_valid_q      <= wb_valid_d;
            pc5_q           <= pc5_d;
            err_unaligned_q <= err_unaligned_d;
            err_timeout_q   <= err_timeout_d;
        end
    end

    assign dmem.req         = req_q;
    assign dmem.we          = we_q;
    assign dmem.addr        = addr_q;
    assign dmem.wdata       = wdata_q;
    assign wb_value_mxwb_p5 = wb_value_q;
    assign wb_index_mxwb_p5 = wb_index_q;
    assign wb_valid_mxwb_p5 = wb_valid_q;
    assign pc_p5            = pc5_q;
    assign err_unaligned    = err_unaligned_q;
    assign err_timeout      = err_timeout_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: a scoreboard of expected P5 results and expected dmem requests,
// with a programmable-latency memory responder.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] dest_value;
    logic [2:0]  dest_index;
    logic        dest_wv;
    logic [15:0] mem_addr;
    logic        ldst_valid;
    logic [1:0]  store_valid;
    logic [15:0] mem_data;
    logic [15:0] pc4;
    logic        stall;
    logic [15:0] wb_value;
    logic [2:0]  wb_index;
    logic        wb_valid;
    logic [15:0] pc5;
    logic        err_unaligned;
    logic        err_timeout;

    mem_stage_if mem ();

    mem_stage #(.TIMEOUT_CYC(4)) dut (
        .clk                           (clk),
        .rst                           (rst),
        .dest_reg_value_ixmem_p4       (dest_value),
        .dest_reg_index_ixmem_p4       (dest_index),
        .dest_reg_write_valid_ixmem_p4 (dest_wv),
        .mem_addr_ixmem_p4             (mem_addr),
        .ldst_valid_ixmem_p4           (ldst_valid),
        .store_valid_ixmem_p4          (store_valid),
        .mem_data_in_ixmem_p4          (mem_data),
        .pc_p4                         (pc4),
        .stall_mem_p4                  (stall),
        .dmem                          (mem.master),
        .wb_value_mxwb_p5              (wb_value),
        .wb_index_mxwb_p5              (wb_index),
        .wb_valid_mxwb_p5              (wb_valid),
        .pc_p5                         (pc5),
        .err_unaligned                 (err_unaligned),
        .err_timeout                   (err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] value;
        logic [2:0]  index;
        logic        valid;
        logic [15:0] pc;
        bit          full;
    } wb_exp_t;

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [15:0] wdata;
        logic [15:0] rdata;
    } req_exp_t;

    wb_exp_t  sb_q[$];
    req_exp_t req_q[$];

    int n_cmp = 0;
    int n_mis = 0;
    bit resp_en;
    int ack_delay;
    int wait_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Memory responder: acks ack_delay cycles after req first appears.
    initial begin
        mem.ack   = 1'b0;
        mem.rdata = 16'd0;
        wait_cnt  = 0;
        forever begin
            @(negedge clk);
            if (resp_en) begin
                mem.ack = 1'b0;
                if (mem.req) begin
                    if (wait_cnt == ack_delay) begin
                        wait_cnt = 0;
                        if (req_q.size() == 0) begin
                            chk("req_unexpected", 32'(1), 32'(0));
                        end else begin
                            req_exp_t r;
                            r = req_q.pop_front();
                            chk("req_addr", 32'(mem.addr), 32'(r.addr));
                            chk("req_we", 32'(mem.we), 32'(r.we));
                            if (r.we) chk("req_wdata", 32'(mem.wdata), 32'(r.wdata));
                            mem.rdata = r.rdata;
                        end
                        mem.ack = 1'b1;
                    end else begin
                        wait_cnt++;
                    end
                end else begin
                    wait_cnt = 0;
                end
            end
        end
    end

    task automatic drive_nop();
        ldst_valid  = 1'b0;
        dest_wv     = 1'b0;
        store_valid = 2'b00;
        mem_addr    = 16'd0;
        mem_data    = 16'd0;
        dest_value  = 16'd0;
        dest_index  = 3'd0;
        pc4         = 16'd0;
    endtask

    // Present one P4 instruction, hold it while stalled, then compare P5 the cycle after release.
    task automatic issue(input string tag, input logic ldst, input logic [1:0] sv,
                         input logic [15:0] addr, input logic [15:0] data,
                         input logic [15:0] value, input logic [2:0] idx, input logic wv,
                         input logic [15:0] pc, input logic [15:0] rdata, input int delay,
                         input logic [15:0] exp_val, input logic exp_wv, input bit full,
                         input int exp_stall, input int exp_req);
        int n_stall;
        int n_req;
        bit released;
        wb_exp_t e;
        n_stall     = 0;
        n_req       = 0;
        released    = 1'b0;
        ack_delay   = delay;
        ldst_valid  = ldst;
        store_valid = sv;
        mem_addr    = addr;
        mem_data    = data;
        dest_value  = value;
        dest_index  = idx;
        dest_wv     = wv;
        pc4         = pc;
        if (ldst && !addr[0] && resp_en) req_q.push_back('{addr, |sv, data, rdata});
        sb_q.push_back('{exp_val, idx, exp_wv, pc, full});
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (mem.req) n_req++;
            if (!stall) begin
                released = 1'b1;
                break;
            end
            n_stall++;
        end
        chk({tag, "_release"}, 32'(released), 32'(1));
        chk({tag, "_stall_cycles"}, 32'(n_stall), 32'(exp_stall));
        chk({tag, "_req_cycles"}, 32'(n_req), 32'(exp_req));
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk({tag, "_wb_valid"}, 32'(wb_valid), 32'(e.valid));
        if (e.full) begin
            chk({tag, "_wb_value"}, 32'(wb_value), 32'(e.value));
            chk({tag, "_wb_index"}, 32'(wb_index), 32'(e.index));
            chk({tag, "_pc5"}, 32'(pc5), 32'(e.pc));
        end
        drive_nop();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst     = 1'b0;
        resp_en = 1'b1;
        ack_delay = 0;
        drive_nop();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", 32'(mem.req), 32'(0));
        chk("rst_wb_valid", 32'(wb_valid), 32'(0));
        chk("rst_wb_value", 32'(wb_value), 32'(0));
        chk("rst_pc5", 32'(pc5), 32'(0));
        chk("rst_errs", 32'({err_unaligned, err_timeout}), 32'(0));
        chk("rst_stall", 32'(stall), 32'(0));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        //    tag    ldst sv     addr      data      value     idx  wv   pc        rdata     dly exp_val   ewv full stl req
        issue("alu", 0, 2'b00, 16'h0000, 16'h0000, 16'h1234, 3'd3, 1, 16'h0010, 16'h0000, 0, 16'h1234, 1, 1, 0, 0);
        issue("ld",  1, 2'b00, 16'h0040, 16'h0000, 16'h5555, 3'd5, 1, 16'h0012, 16'hBEEF, 3, 16'hBEEF, 1, 1, 4, 4);
        issue("stu", 1, 2'b10, 16'h0100, 16'h00AA, 16'h0100, 3'd2, 0, 16'h0014, 16'h0000, 1, 16'h0100, 1, 1, 2, 2);
        issue("st",  1, 2'b01, 16'h0200, 16'h1111, 16'h7777, 3'd1, 1, 16'h0016, 16'h0000, 0, 16'h7777, 0, 1, 1, 1);
        issue("ld2", 1, 2'b00, 16'h0202, 16'h0000, 16'h0000, 3'd4, 1, 16'h0018, 16'h2222, 0, 16'h2222, 1, 1, 1, 1);
        issue("st11",1, 2'b11, 16'h0300, 16'h3333, 16'h9999, 3'd6, 1, 16'h001A, 16'h0000, 2, 16'h9999, 0, 1, 3, 3);
        chk("no_err_unaligned_yet", 32'(err_unaligned), 32'(0));
        issue("mis", 1, 2'b00, 16'h0041, 16'h0000, 16'hAAAA, 3'd7, 1, 16'h001C, 16'h0000, 0, 16'hAAAA, 0, 0, 0, 0);
        chk("err_unaligned", 32'(err_unaligned), 32'(1));
        chk("no_err_timeout_yet", 32'(err_timeout), 32'(0));

        resp_en = 1'b0;
        mem.ack = 1'b0;
        issue("tmo", 1, 2'b00, 16'h0050, 16'h0000, 16'h0000, 3'd1, 1, 16'h001E, 16'h0000, 0, 16'h0000, 0, 0, 4, 4);
        chk("err_timeout", 32'(err_timeout), 32'(1));
        chk("tmo_req_dropped", 32'(mem.req), 32'(0));
        chk("err_unaligned_sticky", 32'(err_unaligned), 32'(1));

        // Reset in the middle of an outstanding load.
        ldst_valid  = 1'b1;
        store_valid = 2'b00;
        mem_addr    = 16'h0060;
        dest_index  = 3'd2;
        dest_wv     = 1'b1;
        pc4         = 16'h0020;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("mid_req_high", 32'(mem.req), 32'(1));
        chk("mid_req_addr", 32'(mem.addr), 32'(16'h0060));
        #2;
        rst = 1'b0;
        #1;
        chk("arst_req", 32'(mem.req), 32'(0));
        chk("arst_addr", 32'(mem.addr), 32'(0));
        chk("arst_errs", 32'({err_unaligned, err_timeout}), 32'(0));
        chk("arst_wb_valid", 32'(wb_valid), 32'(0));
        drive_nop();
        #1;
        chk("arst_stall", 32'(stall), 32'(0));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        mem.ack   = 1'b1;
        mem.rdata = 16'hDEAD;
        @(posedge clk);
        #1;
        mem.ack = 1'b0;
        chk("idle_ack_req", 32'(mem.req), 32'(0));
        chk("idle_ack_wb_valid", 32'(wb_valid), 32'(0));
        chk("idle_ack_stall", 32'(stall), 32'(0));

        resp_en = 1'b1;
        issue("alu2", 0, 2'b00, 16'h0000, 16'h0000, 16'h4321, 3'd6, 1, 16'h0022, 16'h0000, 0, 16'h4321, 1, 1, 0, 0);
        issue("ld3",  1, 2'b00, 16'h0070, 16'h0000, 16'h0000, 3'd3, 1, 16'h0024, 16'h5A5A, 1, 16'h5A5A, 1, 1, 2, 2);
        chk("req_queue_drained", 32'(req_q.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
